// File: rtl/processor_pkg.sv
// Shared constants and types for moving 32-bit memory words into 512-bit vector registers.
package processor_pkg;

    localparam int WORD_W  = 32;
    localparam int LANES   = 16;
    localparam int VEC_W   = WORD_W * LANES;
    localparam int ADDR_W  = 9;
    localparam int RADDR_W = 2;
    localparam int LANE_W  = $clog2(LANES);

    typedef logic [WORD_W-1:0]  word_t;
    typedef logic [VEC_W-1:0]   vec_t;
    typedef logic [ADDR_W-1:0]  maddr_t;
    typedef logic [RADDR_W-1:0] raddr_t;
    typedef logic [LANE_W-1:0]  lane_t;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, WRITE} vload_state_t;

    // True when a LANES-word burst starting at base runs past the top of memory.
    function automatic logic burst_wraps(maddr_t base);
        return ({1'b0, base} + (ADDR_W+1)'(LANES-1)) > (ADDR_W+1)'((1 << ADDR_W) - 1);
    endfunction

endpackage

// File: rtl/vector_load_unit_if.sv
// Command, memory-read and register-file-write signals of the vector load unit.
interface vector_load_unit_if;
    import processor_pkg::*;

    logic   start_valid;
    logic   start_ready;
    maddr_t base_addr;
    raddr_t dest_reg;
    logic   mem_read;
    maddr_t mem_addr;
    word_t  mem_rdata;
    logic   reg_write;
    raddr_t reg_waddr;
    vec_t   reg_wdata;
    logic   wrapped;
    logic   busy;

    modport slave (
        input  start_valid, base_addr, dest_reg, mem_rdata,
        output start_ready, mem_read, mem_addr, reg_write, reg_waddr, reg_wdata, wrapped, busy
    );

    modport master (
        output start_valid, base_addr, dest_reg, mem_rdata,
        input  start_ready, mem_read, mem_addr, reg_write, reg_waddr, reg_wdata, wrapped, busy
    );

endinterface

// File: rtl/vec_pack_buffer.sv
// LANES x WORD_W packing register: one lane written per cycle, whole vector cleared at once.
module vec_pack_buffer
    import processor_pkg::*;
(
    input  logic  clk,
    input  logic  clear_i,
    input  logic  we_i,
    input  lane_t lane_i,
    input  word_t wdata_i,
    output vec_t  vec_o
);

    word_t lanes_q [LANES];

    always_ff @(posedge clk) begin
        for (int k = 0; k < LANES; k++) begin
            if (clear_i) begin
                lanes_q[k] <= '0;
            end else if (we_i && (lane_i == lane_t'(k))) begin
                lanes_q[k] <= wdata_i;
            end
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        assign vec_o[k*WORD_W +: WORD_W] = lanes_q[k];
    end

endmodule

// File: rtl/vector_load_unit.sv
// Reads LANES consecutive memory words from a base address and writes them as one packed vector register.
module vector_load_unit
    import processor_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    vector_load_unit_if.slave  bus
);

    vload_state_t state_q, state_d;
    lane_t        issue_cnt_q, issue_cnt_d;
    lane_t        cap_cnt_q, cap_cnt_d;
    logic         cap_vld_q, cap_vld_d;
    raddr_t       dest_q, dest_d;
    logic         wrap_pend_q, wrap_pend_d;
    logic         start_ready_q, start_ready_d;
    logic         busy_q, busy_d;
    logic         mem_read_q, mem_read_d;
    maddr_t       mem_addr_q, mem_addr_d;
    logic         reg_write_q, reg_write_d;
    raddr_t       reg_waddr_q, reg_waddr_d;
    vec_t         reg_wdata_q, reg_wdata_d;
    logic         wrapped_q, wrapped_d;
    logic         accept;
    vec_t         buf_vec;
    vec_t         full_vec;

    assign accept = bus.start_valid && start_ready_q;

    vec_pack_buffer u_buf (
        .clk     (clk),
        .clear_i (accept),
        .we_i    (cap_vld_q),
        .lane_i  (cap_cnt_q),
        .wdata_i (bus.mem_rdata),
        .vec_o   (buf_vec)
    );

    always_comb begin
        state_d       = state_q;
        issue_cnt_d   = issue_cnt_q;
        cap_vld_d     = mem_read_q;
        cap_cnt_d     = cap_vld_q ? cap_cnt_q + 1'b1 : cap_cnt_q;
        dest_d        = dest_q;
        wrap_pend_d   = wrap_pend_q;
        mem_read_d    = 1'b0;
        mem_addr_d    = mem_addr_q;
        reg_write_d   = 1'b0;
        reg_waddr_d   = reg_waddr_q;
        reg_wdata_d   = reg_wdata_q;
        wrapped_d     = 1'b0;
        // The last word arrives in the same cycle the vector is registered, so merge it in here.
        full_vec      = buf_vec;
        full_vec[int'(cap_cnt_q)*WORD_W +: WORD_W] = bus.mem_rdata;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d     = ISSUE;
                    issue_cnt_d = '0;
                    cap_cnt_d   = '0;
                    dest_d      = bus.dest_reg;
                    wrap_pend_d = burst_wraps(bus.base_addr);
                    mem_read_d  = 1'b1;
                    mem_addr_d  = bus.base_addr;
                end
            end
            ISSUE: begin
                if (issue_cnt_q == lane_t'(LANES-1)) begin
                    state_d = DRAIN;
                end else begin
                    mem_read_d  = 1'b1;
                    mem_addr_d  = mem_addr_q + 1'b1;
                    issue_cnt_d = issue_cnt_q + 1'b1;
                end
            end
            DRAIN: begin
                state_d     = WRITE;
                reg_write_d = 1'b1;
                reg_waddr_d = dest_q;
                reg_wdata_d = full_vec;
                wrapped_d   = wrap_pend_q;
            end
            WRITE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        start_ready_d = (state_d == IDLE);
        busy_d        = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            issue_cnt_q   <= '0;
            cap_cnt_q     <= '0;
            cap_vld_q     <= 1'b0;
            dest_q        <= '0;
            wrap_pend_q   <= 1'b0;
            start_ready_q <= 1'b1;
            busy_q        <= 1'b0;
            mem_read_q    <= 1'b0;
            mem_addr_q    <= '0;
            reg_write_q   <= 1'b0;
            reg_waddr_q   <= '0;
            reg_wdata_q   <= '0;
            wrapped_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            issue_cnt_q   <= issue_cnt_d;
            cap_cnt_q     <= cap_cnt_d;
            cap_vld_q     <= cap_vld_d;
            dest_q        <= dest_d;
            wrap_pend_q   <= wrap_pend_d;
            start_ready_q <= start_ready_d;
            busy_q        <= busy_d;
            mem_read_q    <= mem_read_d;
            mem_addr_q    <= mem_addr_d;
            reg_write_q   <= reg_write_d;
            reg_waddr_q   <= reg_waddr_d;
            reg_wdata_q   <= reg_wdata_d;
            wrapped_q     <= wrapped_d;
        end
    end

    assign bus.start_ready = start_ready_q;
    assign bus.busy        = busy_q;
    assign bus.mem_read    = mem_read_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.reg_write   = reg_write_q;
    assign bus.reg_waddr   = reg_waddr_q;
    assign bus.reg_wdata   = reg_wdata_q;
    assign bus.wrapped     = wrapped_q;

endmodule
